// File: rtl/hls4x2_mul_arbiter.sv
// hls4x2_mul_arbiter: four requesters share one signed multiplier through a
// round-robin arbiter feeding a two-stage pipeline (S1 operands, S2 product).
// A full S2 that is not drained stalls both stages and blocks new grants.
module hls4x2_mul_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_p,
  output logic [1:0]                    rsp_id,
  output logic [15:0]                   ops_count
);

  localparam int ID_W = 2;

  // S1 stage
  logic                         r_s1_valid;
  logic signed [DATA_WIDTH-1:0] r_s1_a;
  logic signed [DATA_WIDTH-1:0] r_s1_b;
  logic [ID_W-1:0]              r_s1_id;

  // S2 stage (drives the response port directly)
  logic                         r_s2_valid;
  logic [DATA_WIDTH-1:0]        r_s2_p;
  logic [ID_W-1:0]              r_s2_id;

  logic [ID_W-1:0]              r_last_grant;
  logic [15:0]                  r_ops_count;

  logic                         w_advance;
  logic                         w_found;
  logic [ID_W-1:0]              w_win;
  logic [ID_W-1:0]              w_idx;
  logic                         w_accept;
  logic signed [DATA_WIDTH-1:0] w_prod;

  // Both stages move together only when S2 is empty or being drained.
  assign w_advance = !r_s2_valid || rsp_ready;
  assign w_accept  = !ap_rst && w_advance && w_found;

  // A DATA_WIDTH-wide product of DATA_WIDTH-wide operands is exactly the low
  // half of the full-width two's-complement product, i.e. wrapping truncation.
  assign w_prod = r_s1_a * r_s1_b;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_last_grant;
    w_idx   = r_last_grant;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = r_last_grant + ID_W'(k);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end else begin
        w_found = w_found;
      end
    end
  end

  // One-hot accept toward the winning requester; silent during reset or stall.
  always_comb begin
    req_ready = '0;
    if (w_accept) begin
      req_ready[w_win] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Pipeline, arbitration pointer and completion counter.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_s1_valid   <= 1'b0;
      r_s1_a       <= '0;
      r_s1_b       <= '0;
      r_s1_id      <= '0;
      r_s2_valid   <= 1'b0;
      r_s2_p       <= '0;
      r_s2_id      <= '0;
      r_last_grant <= 2'd3;
      r_ops_count  <= 16'd0;
    end else begin
      if (w_advance) begin
        r_s2_valid <= r_s1_valid;
        r_s2_p     <= w_prod;
        r_s2_id    <= r_s1_id;
        r_s1_valid <= w_accept;
        if (w_accept) begin
          r_s1_a       <= req_a[w_win*DATA_WIDTH +: DATA_WIDTH];
          r_s1_b       <= req_b[w_win*DATA_WIDTH +: DATA_WIDTH];
          r_s1_id      <= w_win;
          r_last_grant <= w_win;
        end
      end
      if (r_s2_valid && rsp_ready) begin
        r_ops_count <= r_ops_count + 16'd1;
      end
    end
  end

  assign rsp_valid = r_s2_valid;
  assign rsp_p     = r_s2_p;
  assign rsp_id    = r_s2_id;
  assign ops_count = r_ops_count;

endmodule

// File: doc/hls4x2_mul_arbiter.md
HLS4X2_MUL_ARBITER -- requirements
Module: hls4x2_mul_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (fixed at 4 for this revision).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, operand and product width in bits.
REQ-003 SHALL have port ap_clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port ap_rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  4  per-requester operation request.
REQ-006 SHALL have port req_ready  output  4  per-requester accept; at most one bit set.
REQ-007 SHALL have port req_a  input  64  packed signed operand A; requester i uses bits [16i+15:16i].
REQ-008 SHALL have port req_b  input  64  packed signed operand B, packed the same way as req_a.
REQ-009 SHALL have port rsp_valid  output  1  product available.
REQ-010 SHALL have port rsp_ready  input  1  downstream accepts the product.
REQ-011 SHALL have port rsp_p  output  16  signed product.
REQ-012 SHALL have port rsp_id  output  2  index of the requester that owns rsp_p.
REQ-013 SHALL have port ops_count  output  16  count of completed responses.

Function
REQ-014 SHALL share one 16x16 signed multiplier among 4 requesters using a 2-stage pipeline.
- S1 registers a, b, id and valid.
- S2 registers the product, id and valid.
REQ-015 SHALL define advance = !s2_valid || rsp_ready; when advance is 0, S1 and S2 SHALL both hold their contents.
REQ-016 SHALL assert req_ready[i] combinationally only when all of the following hold: advance = 1, req_valid[i] = 1, and i is the round-robin winner.
REQ-017 SHALL pick the round-robin winner as the first requester with req_valid set, searching from (last_grant+1) mod 4 upward and wrapping 3->0.
REQ-018 SHALL treat a request as accepted when req_valid[i] && req_ready[i]; on acceptance S1 loads req_a/req_b slice i and id = i, and last_grant updates to i.
REQ-019 SHALL leave last_grant unchanged on cycles with no acceptance.
REQ-020 SHALL load S1 valid = 0 on advance cycles with no acceptance (bubble).
REQ-021 SHALL compute S2 product = low 16 bits of the signed 32-bit product of the S1 operands (two's-complement truncation, no saturation).
REQ-022 SHALL drive rsp_valid, rsp_p and rsp_id directly from S2.
REQ-023 SHALL complete a response when rsp_valid && rsp_ready.
REQ-024 SHALL give a latency of exactly 2 cycles from acceptance to rsp_valid when there is no backpressure, and sustain 1 operation per cycle.
REQ-025 SHALL keep rsp_p and rsp_id stable while rsp_valid = 1 and rsp_ready = 0.
REQ-026 SHALL increment ops_count by 1 on each completed response, wrapping 0xFFFF -> 0x0000.
REQ-027 SHALL accept a new request and complete a response in the same cycle when rsp_ready = 1 and S2 is valid.
REQ-028 SHALL NOT lose, duplicate or reorder operations; responses leave in acceptance order.
REQ-029 SHALL let a requester that drops req_valid before acceptance drop out without any state change.

Reset
REQ-030 SHALL, while ap_rst = 1 at a clock edge, clear:
- S1 valid and S2 valid to 0;
- rsp_valid to 0, rsp_p to 0, rsp_id to 0;
- ops_count to 0;
- last_grant to 3, so requester 0 has first priority.
REQ-031 SHALL drive req_ready = 0 during reset.
REQ-032 SHALL discard in-flight operations on reset mid-operation, with no response emitted for them.

Verification
REQ-033 Single op: requester 2 issues a=3, b=-4, rsp_ready=1 -> req_ready=0100 in cycle 0; rsp_valid in cycle 2 with rsp_p=0xFFF4 (-12), rsp_id=2; ops_count=1.
REQ-034 Fairness: all 4 requesters hold valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3; ops_count=8 after drain.
REQ-035 Backpressure: 3 back-to-back ops, then rsp_ready=0 for 5 cycles -> rsp_p held constant, req_ready=0000, no op lost; all 3 responses arrive in order once rsp_ready=1.
REQ-036 Truncation: a=0x4000, b=0x0004 -> rsp_p=0x0000; a=-32768, b=-1 -> rsp_p=0x8000.
REQ-037 Reset mid-flight: 2 ops in the pipe, ap_rst for 1 cycle -> rsp_valid=0 and ops_count=0 next cycle; the first grant after reset goes to requester 0.
REQ-038 Counter wrap: preload 65535 completions (or force ops_count=0xFFFF), then 1 more completion -> ops_count=0x0000.
